// File: rtl/alu_exec.sv
// Execute-stage ALU: registered ALU/branch results with an iterative one-bit-per-cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [3:0]      alu_ctrl_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            branch_taken_o,
  output logic            dbg_state
);

  // Handshake: an op is taken on a rising edge with valid_i && ready_o && !flush_i;
  // upstream holds its inputs while ready_o is low; valid_o is a one-cycle pulse, no backpressure.
  logic [4:0]      shamt;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic            take;
  logic [XLEN-1:0] sll_res, srl_res, sra_res;

  assign shamt  = op_b_i[4:0];
  assign accept = valid_i && ready_o && !flush_i;

`ifdef ALU_FAST_SHIFT_EN
  assign sll_res = op_a_i << shamt;
  assign srl_res = op_a_i >> shamt;
  assign sra_res = $signed(op_a_i) >>> shamt;
`else
  // Only reached with shamt 0; nonzero amounts go through the SHIFT state.
  assign sll_res = op_a_i;
  assign srl_res = op_a_i;
  assign sra_res = op_a_i;
`endif

  always_comb begin
    alu_res = '0;
    take    = 1'b0;
    if (branch_i) begin
      case (alu_ctrl_i[2:0])
        3'b000:  take = (op_a_i == op_b_i);
        3'b001:  take = (op_a_i != op_b_i);
        3'b100:  take = ($signed(op_a_i) <  $signed(op_b_i));
        3'b101:  take = ($signed(op_a_i) >= $signed(op_b_i));
        3'b110:  take = (op_a_i <  op_b_i);
        3'b111:  take = (op_a_i >= op_b_i);
        default: take = 1'b0;
      endcase
    end else begin
      case (alu_ctrl_i)
        4'b0000: alu_res = op_a_i + op_b_i;
        4'b1000: alu_res = op_a_i - op_b_i;
        4'b0001: alu_res = sll_res;
        4'b0101: alu_res = srl_res;
        4'b1101: alu_res = sra_res;
        4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
        4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
        4'b0100: alu_res = op_a_i ^ op_b_i;
        4'b0110: alu_res = op_a_i | op_b_i;
        4'b0111: alu_res = op_a_i & op_b_i;
        default: alu_res = '0;
      endcase
    end
  end

`ifdef ALU_FAST_SHIFT_EN
  assign ready_o   = 1'b1;
  assign dbg_state = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o        <= 1'b0;
      result_o       <= '0;
      zero_o         <= 1'b0;
      branch_taken_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        result_o       <= alu_res;
        zero_o         <= (alu_res == '0);
        branch_taken_o <= take;
        valid_o        <= 1'b1;
      end
    end
  end
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            is_shift;
  logic [XLEN-1:0] work_q, work_nxt;
  logic [4:0]      cnt_q;
  logic            left_q, arith_q;

  assign is_shift  = !branch_i && ((alu_ctrl_i == 4'b0001) || (alu_ctrl_i == 4'b0101) ||
                                   (alu_ctrl_i == 4'b1101));
  assign ready_o   = (state_q == IDLE);
  assign dbg_state = (state_q == SHIFT);
  assign work_nxt  = left_q ? {work_q[XLEN-2:0], 1'b0}
                            : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_shift && (shamt != 5'd0)) state_d = SHIFT;
      SHIFT:   if (flush_i || (cnt_q == 5'd1))            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o        <= 1'b0;
      result_o       <= '0;
      zero_o         <= 1'b0;
      branch_taken_o <= 1'b0;
      work_q         <= '0;
      cnt_q          <= '0;
      left_q         <= 1'b0;
      arith_q        <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (state_q == IDLE) begin
        if (accept && is_shift && (shamt != 5'd0)) begin
          work_q  <= op_a_i;
          cnt_q   <= shamt;
          left_q  <= (alu_ctrl_i == 4'b0001);
          arith_q <= alu_ctrl_i[3];
        end else if (accept) begin
          result_o       <= alu_res;
          zero_o         <= (alu_res == '0);
          branch_taken_o <= take;
          valid_o        <= 1'b1;
        end
      end else if (!flush_i) begin
        // A flush abandons the shift and leaves the result registers untouched.
        work_q <= work_nxt;
        cnt_q  <= cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_o       <= work_nxt;
          zero_o         <= (work_nxt == '0);
          branch_taken_o <= 1'b0;
          valid_o        <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: directed vector table, hand-written flush/reset/back-to-back
// sequences, and randomized ops checked against a behavioural model.
module tb_alu_exec;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_i;
  logic            ready_o;
  logic            flush_i;
  logic [3:0]      alu_ctrl_i;
  logic            branch_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            branch_taken_o;
  logic            dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [3:0]      ctrl;
    logic            br;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            z;
    logic            t;
  } vec_t;

  vec_t vecs[19];

  alu_exec #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .flush_i        (flush_i),
    .alu_ctrl_i     (alu_ctrl_i),
    .branch_i       (branch_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .valid_o        (valid_o),
    .result_o       (result_o),
    .zero_o         (zero_o),
    .branch_taken_o (branch_taken_o),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural reference: results straight from the ISA rules, plus the expected
  // latency and number of stall cycles for the build being simulated.
  function automatic void model(input logic [3:0] c, input logic br,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                output logic [XLEN-1:0] r, output logic z, output logic t,
                                output int lat, output int rlow);
    int sh;
    sh = int'(b[4:0]);
    r  = '0;
    t  = 1'b0;
    if (br) begin
      case (c[2:0])
        3'd0:    t = (a == b);
        3'd1:    t = (a != b);
        3'd4:    t = ($signed(a) < $signed(b));
        3'd5:    t = ($signed(a) >= $signed(b));
        3'd6:    t = (a < b);
        3'd7:    t = (a >= b);
        default: t = 1'b0;
      endcase
    end else begin
      case (c)
        4'd0:    r = a + b;
        4'd8:    r = a - b;
        4'd1:    r = a << sh;
        4'd5:    r = a >> sh;
        4'd13:   r = $signed(a) >>> sh;
        4'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd3:    r = (a < b) ? 32'd1 : 32'd0;
        4'd4:    r = a ^ b;
        4'd6:    r = a | b;
        4'd7:    r = a & b;
        default: r = '0;
      endcase
    end
    z    = (r == '0);
    lat  = 1;
    rlow = 0;
`ifndef ALU_FAST_SHIFT_EN
    if (!br && (c == 4'd1 || c == 4'd5 || c == 4'd13) && sh != 0) begin
      lat  = sh + 1;
      rlow = sh;
    end
`endif
  endfunction

  // ---------------- driver ----------------
  // Issues one op at a negedge and follows it to its valid_o pulse (bounded), then
  // samples one more cycle to catch a repeated pulse.
  task automatic run_op(input logic [3:0] c, input logic br,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output logic [XLEN-1:0] r, output logic z, output logic t,
                        output int lat, output int rlow, output logic rdy_done,
                        output logic extra);
    int guard;
    guard = 0;
    while (!ready_o && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    alu_ctrl_i = c;
    branch_i   = br;
    op_a_i     = a;
    op_b_i     = b;
    valid_i    = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    lat     = 1;
    rlow    = 0;
    while (!valid_o && lat < 40) begin
      if (!ready_o) rlow++;
      @(negedge clk);
      lat++;
    end
    r        = result_o;
    z        = zero_o;
    t        = branch_taken_o;
    rdy_done = ready_o;
    @(negedge clk);
    extra = valid_o;
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic br, input logic [XLEN-1:0] a,
                              input logic [XLEN-1:0] b, input logic [XLEN-1:0] res,
                              input logic z, input logic t);
    vec_t v;
    v.ctrl = c; v.br = br; v.a = a; v.b = b; v.res = res; v.z = z; v.t = t;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [XLEN-1:0] r, mr, last_res;
    logic            z, t, mz, mt, rdy_done, extra;
    int              lat, rlow, mlat, mrlow, pulses;
    logic [3:0]      codes[10];

    codes = '{4'd0, 4'd8, 4'd1, 4'd5, 4'd13, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};

    vecs[0]  = mk(4'b0000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
    vecs[1]  = mk(4'b1000, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0);
    vecs[2]  = mk(4'b0100, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1);
    vecs[3]  = mk(4'b0110, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    vecs[4]  = mk(4'b1101, 1'b0, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0);
    vecs[5]  = mk(4'b0111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    vecs[6]  = mk(4'b0010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    vecs[7]  = mk(4'b0011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    vecs[8]  = mk(4'b0100, 1'b0, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1'b0);
    vecs[9]  = mk(4'b0110, 1'b0, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0, 1'b0);
    vecs[10] = mk(4'b0001, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0);
    vecs[11] = mk(4'b0101, 1'b0, 32'h80000000, 32'h00000020, 32'h80000000, 1'b0, 1'b0);
    vecs[12] = mk(4'b1001, 1'b0, 32'h12345678, 32'h00000003, 32'h00000000, 1'b1, 1'b0);
    vecs[13] = mk(4'b0010, 1'b1, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0);
    vecs[14] = mk(4'b0000, 1'b1, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b1);
    vecs[15] = mk(4'b0101, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    vecs[16] = mk(4'b0111, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1);
    vecs[17] = mk(4'b0001, 1'b1, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b1);
    vecs[18] = mk(4'b0000, 1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1'b0);

    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; alu_ctrl_i = '0; branch_i = 1'b0;
    op_a_i = '0; op_b_i = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", ready_o, 1'b1);
    check("reset_valid", valid_o, 1'b0);
    check("reset_result", result_o, '0);
    check("reset_zero", zero_o, 1'b0);
    check("reset_taken", branch_taken_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 19; i++) begin
      model(vecs[i].ctrl, vecs[i].br, vecs[i].a, vecs[i].b, mr, mz, mt, mlat, mrlow);
      run_op(vecs[i].ctrl, vecs[i].br, vecs[i].a, vecs[i].b, r, z, t, lat, rlow, rdy_done, extra);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_zero", i), z, vecs[i].z);
      check($sformatf("vec%0d_taken", i), t, vecs[i].t);
      check($sformatf("vec%0d_latency", i), lat, mlat);
      check($sformatf("vec%0d_stall", i), rlow, mrlow);
      check($sformatf("vec%0d_ready_done", i), rdy_done, 1'b1);
      check($sformatf("vec%0d_single_pulse", i), extra, 1'b0);
    end

    // Back-to-back accepts of single-cycle ops, scoreboarded through exp_q.
    for (int i = 0; i < 8; i++) begin
      alu_ctrl_i = codes[(i % 2 == 0) ? 0 : 7 + (i % 3)];
      branch_i   = (i == 5);
      op_a_i     = $urandom;
      op_b_i     = $urandom;
      valid_i    = 1'b1;
      model(alu_ctrl_i, branch_i, op_a_i, op_b_i, mr, mz, mt, mlat, mrlow);
      exp_q.push_back(mr);
      @(negedge clk);
      check("b2b_valid", valid_o, 1'b1);
      check("b2b_ready", ready_o, 1'b1);
      if (exp_q.size() == 0) check("b2b_queue", 32'd0, 32'd1);
      else check("b2b_result", result_o, exp_q.pop_front());
    end
    valid_i = 1'b0;
    @(negedge clk);
    check("b2b_drain", valid_o, 1'b0);
    last_res = mr;

    // Flush while idle blocks acceptance.
    alu_ctrl_i = 4'b0000; branch_i = 1'b0; op_a_i = 32'd1; op_b_i = 32'd1;
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    check("idle_flush_valid", valid_o, 1'b0);
    check("idle_flush_result", result_o, last_res);
    @(negedge clk);
    check("idle_flush_late", valid_o, 1'b0);

`ifndef ALU_FAST_SHIFT_EN
    // Flush in the 10th SHIFT cycle of SLL 1<<31.
    run_op(4'b0000, 1'b0, 32'h00001234, 32'h00000001, r, z, t, lat, rlow, rdy_done, extra);
    alu_ctrl_i = 4'b0001; op_a_i = 32'd1; op_b_i = 32'd31; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    check("shift_busy_state", dbg_state, 1'b1);
    check("shift_busy_ready", ready_o, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_valid", valid_o, 1'b0);
    check("flush_ready", ready_o, 1'b1);
    check("flush_result", result_o, 32'h00001235);
    pulses = 0;
    repeat (35) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    check("flush_no_late_pulse", pulses, 0);
`endif

    // Asynchronous reset in the middle of SRL by 20.
    run_op(4'b0000, 1'b0, 32'h00000100, 32'h00000023, r, z, t, lat, rlow, rdy_done, extra);
    check("pre_reset_result", r, 32'h00000123);
    alu_ctrl_i = 4'b0101; op_a_i = 32'hFFFFFFFF; op_b_i = 32'd20; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_ready", ready_o, 1'b1);
    check("mid_reset_valid", valid_o, 1'b0);
    check("mid_reset_result", result_o, '0);
    check("mid_reset_zero", zero_o, 1'b0);
    check("mid_reset_taken", branch_taken_o, 1'b0);
    check("mid_reset_state", dbg_state, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    check("post_reset_no_pulse", pulses, 0);
    run_op(4'b0111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, r, z, t, lat, rlow, rdy_done, extra);
    check("post_reset_and", r, 32'hF000F000);
    check("post_reset_and_latency", lat, 1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 250; i++) begin
      logic [3:0]      c;
      logic            br;
      logic [XLEN-1:0] a, b;
      br = ($urandom_range(0, 3) == 0);
      if (br)                             c = 4'($urandom_range(0, 7));
      else if ($urandom_range(0, 9) < 8)  c = codes[$urandom_range(0, 9)];
      else                                c = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 40));
        2:       b = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
        default: b = $urandom;
      endcase
      model(c, br, a, b, mr, mz, mt, mlat, mrlow);
      run_op(c, br, a, b, r, z, t, lat, rlow, rdy_done, extra);
      check($sformatf("rnd%0d_result c=%h br=%0d", i, c, br), r, mr);
      check($sformatf("rnd%0d_zero", i), z, mz);
      check($sformatf("rnd%0d_taken", i), t, mt);
      check($sformatf("rnd%0d_latency", i), lat, mlat);
      check($sformatf("rnd%0d_stall", i), rlow, mrlow);
      check($sformatf("rnd%0d_ready_done", i), rdy_done, 1'b1);
      check($sformatf("rnd%0d_single_pulse", i), extra, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the RISCV-Lite core, sitting directly downstream of the ALU control decoder and consuming its 4-bit `ALUControl_Enum` code together with the two operands. It registers every result into the EX/MEM boundary, resolves branch conditions, and implements shifts with an iterative one-bit-per-cycle shifter. While a shift is in flight it deasserts `ready_o` so the hazard unit can stall the front end.

## Interface
Parameters:
- `XLEN`, 32, operand and result width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  operands and control are valid this cycle.
- `ready_o`  out  1  block can accept an operation this cycle.
- `flush_i`  in  1  synchronous kill of any in-flight operation.
- `alu_ctrl_i`  in  4  `ALUControl_Enum` code.
- `branch_i`  in  1  1 means `alu_ctrl_i[2:0]` is a branch func3 compare.
- `op_a_i`  in  XLEN  operand A (rs1).
- `op_b_i`  in  XLEN  operand B (rs2 or immediate).
- `valid_o`  out  1  one-cycle pulse when the result registers update.
- `result_o`  out  XLEN  registered result, held until the next `valid_o`.
- `zero_o`  out  1  registered flag, set when `result_o == 0`.
- `branch_taken_o`  out  1  registered branch outcome.

## Operation
- Handshake: an operation is accepted on an edge where `valid_i && ready_o && !flush_i`. `valid_i` while `ready_o=0` is ignored, and upstream holds its inputs. There is no downstream backpressure.
- Codes with `branch_i=0`:
  - 0000 ADD, 1000 SUB
  - 0001 SLL, 0101 SRL, 1101 SRA
  - 0010 SLT (signed), 0011 SLTU
  - 0100 XOR, 0110 OR, 0111 AND
  - Any other code gives `result_o=0`.
- Arithmetic wraps modulo 2^XLEN. SLT/SLTU produce 0 or 1 zero-extended.
- Shift amount is `op_b_i[4:0]`, and upper bits are ignored.
- Branch codes (`branch_i=1`), selected by func3:
  - 000 EQ, 001 NE
  - 100 LT, 101 GE (signed)
  - 110 LTU, 111 GEU (unsigned)
  - 010 and 011 give not-taken.
  - On a branch, `result_o=0`, `zero_o=1`, and `branch_taken_o` carries the compare outcome.
  - On a non-branch, `branch_taken_o=0`.
- FSM states: IDLE, SHIFT.
  - IDLE: `ready_o=1`.
    - Non-shift, or shift with shamt 0: the result registers load on the accept edge.
    - Shift with shamt k>0: load work register = `op_a_i`, counter = k, latch the direction and arithmetic flag, then go to SHIFT.
  - SHIFT: `ready_o=0`. Each edge shifts the work register one bit (SRA replicates the sign bit) and decrements the counter. On the edge where the counter goes 1→0, load `result_o`, pulse `valid_o`, and return to IDLE.
- `flush_i`:
  - In SHIFT: return to IDLE at the next edge with no `valid_o`, and the result registers are unchanged.
  - In IDLE: blocks acceptance that cycle.
  - `flush_i` has priority over completion.
- Reset (any time, including mid-shift):
  - State goes to IDLE immediately.
  - `valid_o=0`, `result_o=0`, `zero_o=0`, `branch_taken_o=0`, `ready_o=1`.

## Timing
- Non-shift, branch, and shamt-0 operations:
  - Accepted at edge E0; `valid_o` is high in the cycle after E0 (latency 1).
  - `ready_o` stays 1, so back-to-back accepts are allowed every cycle.
- Shift with shamt k>0, accepted at edge E0:
  - `ready_o=0` from the cycle after E0 through the cycle after E(k-1).
  - `valid_o` pulses in the cycle after Ek.
  - `ready_o=1` again in that same cycle, so a new op can be accepted on edge E(k+1).
  - Worst case: k=31 holds `ready_o` low for 31 cycles.
- `valid_o` is never high for two consecutive cycles from a single operation.

## Configuration
- `ALU_FAST_SHIFT_EN`:
  - Defined: shifts use a single-cycle barrel shifter with latency 1 for every shamt. The SHIFT state and counter are not built, and `ready_o` is tied to 1.
  - Undefined: the iterative shifter described above is used.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → `result_o=0x80000000`, `zero_o=0`, one cycle after accept. Then SUB 5−5 → `result_o=0`, `zero_o=1`.
- Branch func3=100 with a=0xFFFFFFFF, b=1 → `branch_taken_o=1`. Same operands with func3=110 → `branch_taken_o=0`, and `result_o=0` in both cases.
- SRA a=0x80000000, shamt=4 → `ready_o` low for 4 cycles, then `valid_o` pulses with `result_o=0xF8000000`. With `ALU_FAST_SHIFT_EN`, the same result arrives one cycle after accept.
- SLL a=1, shamt=31, with `flush_i` asserted in the 10th cycle of SHIFT → no `valid_o`, `ready_o=1` the next cycle, and `result_o` keeps its prior value.
- `rst_n` asserted low during an SRL with shamt=20 → all outputs are 0 and `ready_o=1` immediately. After release, AND 0xF0F0F0F0 & 0xFF00FF00 → `result_o=0xF000F000`.
